// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the pipeline hazard controller
//   FWD_* : EX operand select encodings
//   sb_entry_t : one in-flight register writer record
//   state_t : controller state encoding
package pipe_pkg;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] wreg;
        logic       rfwe;
        logic       mtorf;
    } sb_entry_t;

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    // $0 is never a writer, so it can never match and never forwards
    function automatic logic is_writer(sb_entry_t e);
        return e.valid & e.rfwe & (e.wreg != 5'd0);
    endfunction

    // newest producer (EX) takes priority over the older one (MEM)
    function automatic logic [1:0] fwd_sel(logic [4:0] r, sb_entry_t ex, sb_entry_t mem);
        return (is_writer(ex) && ex.wreg == r) ? FWD_MEM :
               (is_writer(mem) && mem.wreg == r) ? FWD_WB : FWD_RF;
    endfunction
endpackage

// File: rtl/pipe_sb_entry.sv
// pipe_sb_entry: one scoreboard register
//   clk, rst : clock, async active-high reset (entry invalid)
//   hold     : keep current contents
//   clr      : load an invalid entry (bubble)
//   d, q     : next / current entry
module pipe_sb_entry
    import pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      hold,
    input  logic      clr,
    input  sb_entry_t d,
    output sb_entry_t q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (!hold)
            q <= clr ? '0 : d;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch/jump flush, EX forwarding and memory freeze
//   inputs : ID instruction fields, id_jump, ex_branch_taken, dm_access/dm_ready
//   outputs: stall_if, stall_id, flush_id, bubble_ex, freeze (combinational),
//            fwd_a/fwd_b (registered EX selects), stall_cnt (saturating)
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_rfwe,
    input  logic             id_mtorf,
    input  logic [4:0]       id_wreg,
    input  logic             id_jump,
    input  logic             ex_branch_taken,
    input  logic             dm_access,
    input  logic             dm_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic             freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);
    state_t    state;
    sb_entry_t id_e, ex_e, mem_e;
    logic      load_use;

    assign id_e = '{valid: id_valid, wreg: id_wreg, rfwe: id_rfwe, mtorf: id_mtorf};

    assign load_use = id_valid & is_writer(ex_e) & ex_e.mtorf &
                      ((id_uses_rs & (ex_e.wreg == id_rs)) | (id_uses_rt & (ex_e.wreg == id_rt)));

    assign freeze    = !dm_ready & ((state == MEM_WAIT) | dm_access);
    // a taken branch squashes the dependent instruction, so the load-use stall is moot
    assign stall_if  = !freeze & !ex_branch_taken & load_use;
    assign stall_id  = stall_if;
    assign bubble_ex = !freeze & (ex_branch_taken | load_use);
    assign flush_id  = !freeze & (ex_branch_taken | (id_jump & id_valid));

    pipe_sb_entry u_ex  (.clk(clk), .rst(rst), .hold(freeze), .clr(bubble_ex), .d(id_e), .q(ex_e));
    pipe_sb_entry u_mem (.clk(clk), .rst(rst), .hold(freeze), .clr(1'b0),      .d(ex_e), .q(mem_e));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            fwd_a     <= FWD_RF;
            fwd_b     <= FWD_RF;
            stall_cnt <= '0;
        end else begin
            state <= (state == RUN) ? ((dm_access & !dm_ready) ? MEM_WAIT : RUN)
                                    : (dm_ready ? RUN : MEM_WAIT);
            if (!freeze) begin
                fwd_a <= bubble_ex ? FWD_RF : fwd_sel(id_rs, ex_e, mem_e);
                fwd_b <= bubble_ex ? FWD_RF : fwd_sel(id_rt, ex_e, mem_e);
            end
            if ((stall_if | freeze) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table with a post-edge scoreboard, plus reset and saturation sequences
module tb_pipe_hazard_ctrl;
    logic       clk, rst;
    logic       id_valid, id_uses_rs, id_uses_rt, id_rfwe, id_mtorf, id_jump;
    logic [4:0] id_rs, id_rt, id_wreg;
    logic       ex_branch_taken, dm_access, dm_ready;
    logic       stall_if, stall_id, flush_id, bubble_ex, freeze;
    logic [1:0] fwd_a, fwd_b;
    logic [2:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rfwe(id_rfwe), .id_mtorf(id_mtorf), .id_wreg(id_wreg),
        .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
        .dm_access(dm_access), .dm_ready(dm_ready),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
        .bubble_ex(bubble_ex), .freeze(freeze),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt;
        logic       urs, urt, we, ld;
        logic [4:0] wr;
        logic       jmp, br, dacc, drdy;
        logic [4:0] comb;
        logic [1:0] fa, fb;
        logic [2:0] cnt;
    } vec_t;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic [2:0] cnt;
    } post_t;

    localparam int NV = 17;
    vec_t  tv [NV];
    post_t sbq [$];

    function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                                logic we, logic ld, logic [4:0] wr, logic jmp, logic br,
                                logic dacc, logic drdy, logic [4:0] comb,
                                logic [1:0] fa, logic [1:0] fb, logic [2:0] cnt);
        vec_t t;
        t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt; t.we = we; t.ld = ld;
        t.wr = wr; t.jmp = jmp; t.br = br; t.dacc = dacc; t.drdy = drdy;
        t.comb = comb; t.fa = fa; t.fb = fb; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_uses_rs = t.urs; id_uses_rt = t.urt;
        id_rfwe = t.we; id_mtorf = t.ld; id_wreg = t.wr; id_jump = t.jmp;
        ex_branch_taken = t.br; dm_access = t.dacc; dm_ready = t.drdy;
    endtask

    function automatic logic [4:0] comb_now();
        return {stall_if, stall_id, flush_id, bubble_ex, freeze};
    endfunction

    initial begin
        post_t p;
        // comb = {stall_if, stall_id, flush_id, bubble_ex, freeze}
        //            v rs rt urs urt we ld wr jmp br dacc drdy comb     fa fb cnt
        tv[0]  = mk(1, 1, 0, 1, 0, 1, 1, 8, 0, 0, 0, 0, 5'b00000, 0, 0, 0); // lw $8
        tv[1]  = mk(1, 8, 8, 1, 1, 1, 0, 9, 0, 0, 0, 0, 5'b11010, 0, 0, 1); // add $9,$8,$8 stalls
        tv[2]  = mk(1, 8, 8, 1, 1, 1, 0, 9, 0, 0, 0, 0, 5'b00000, 1, 1, 1); // retry: load in MEM
        tv[3]  = mk(1, 1, 2, 1, 1, 1, 0, 3, 0, 0, 0, 0, 5'b00000, 0, 0, 1); // add $3
        tv[4]  = mk(1, 3, 9, 1, 1, 1, 0, 4, 0, 0, 0, 0, 5'b00000, 2, 1, 1); // sub $4,$3,$9
        tv[5]  = mk(1, 4, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 2, 0, 1); // write $0
        tv[6]  = mk(1, 0, 0, 1, 1, 1, 0, 5, 0, 0, 0, 0, 5'b00000, 0, 0, 1); // read $0
        tv[7]  = mk(1, 1, 1, 1, 1, 1, 0, 5, 0, 0, 0, 0, 5'b00000, 0, 0, 1); // second $5 writer
        tv[8]  = mk(1, 5, 5, 1, 1, 1, 0, 6, 0, 0, 0, 0, 5'b00000, 2, 2, 1); // EX and MEM both $5
        tv[9]  = mk(1, 6, 0, 1, 0, 1, 1, 7, 0, 0, 0, 0, 5'b00000, 2, 0, 1); // lw $7
        tv[10] = mk(1, 7, 7, 1, 1, 1, 0, 2, 0, 1, 0, 0, 5'b00110, 0, 0, 1); // branch + load-use
        tv[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00100, 0, 0, 1); // jump
        tv[12] = mk(1, 1, 2, 1, 1, 1, 0,10, 0, 0, 0, 0, 5'b00000, 0, 0, 1); // add $10
        tv[13] = mk(1,10,10, 1, 1, 1, 0,11, 0, 0, 1, 0, 5'b00001, 0, 0, 2); // freeze 1
        tv[14] = mk(1,10,10, 1, 1, 1, 0,11, 0, 1, 1, 0, 5'b00001, 0, 0, 3); // freeze 2 + branch
        tv[15] = mk(1,10,10, 1, 1, 1, 0,11, 0, 0, 1, 0, 5'b00001, 0, 0, 4); // freeze 3
        tv[16] = mk(1,10,10, 1, 1, 1, 0,11, 0, 0, 1, 1, 5'b00000, 2, 2, 4); // ready: add $10 still in EX

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 0, 0, 0));
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("reset_comb", 32'(comb_now()), 32'd0);
        chk("reset_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        chk("reset_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                p = sbq.pop_front();
                chk($sformatf("post[%0d]", i - 1), 32'({fwd_a, fwd_b, stall_cnt}), 32'(p));
            end
            drive(tv[i]);
            #3;
            chk($sformatf("comb[%0d]", i), 32'(comb_now()), 32'(tv[i].comb));
            sbq.push_back('{fa: tv[i].fa, fb: tv[i].fb, cnt: tv[i].cnt});
        end
        @(posedge clk);
        #1;
        p = sbq.pop_front();
        chk($sformatf("post[%0d]", NV - 1), 32'({fwd_a, fwd_b, stall_cnt}), 32'(p));

        // enter MEM_WAIT, then reset asynchronously mid-cycle
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b0, 0, 0, 0));
        #3;
        chk("mw_freeze", 32'(freeze), 32'd1);
        @(posedge clk);
        #1;
        chk("mw_fwd_held", 32'({fwd_a, fwd_b}), 32'hA);
        chk("mw_cnt", 32'(stall_cnt), 32'd5);
        #2;
        dm_access = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mw_freeze", 32'(freeze), 32'd0);
        chk("rst_mw_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        chk("rst_mw_cnt", 32'(stall_cnt), 32'd0);
        #1 rst = 1'b0;

        // long freeze saturates the 3-bit counter
        dm_access = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        chk("sat_freeze", 32'(freeze), 32'd1);
        chk("sat_cnt", 32'(stall_cnt), 32'd7);
        dm_ready = 1'b1;
        #1;
        chk("sat_release", 32'(freeze), 32'd0);
        @(posedge clk);
        #1;
        chk("sat_cnt_hold", 32'(stall_cnt), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
